// File: rtl/alu_arb_pkg.sv
// Shared types and widths for the ALU-sharing arbiter.
package alu_arb_pkg;

    localparam int OP_W   = 3;
    localparam int DATA_W = 8;
    localparam int RES_W  = 16;
    localparam int WDOG_W = 8;

    localparam logic [2:0] S_IDLE_ENC    = 3'd0;
    localparam logic [2:0] S_LAUNCH_ENC  = 3'd1;
    localparam logic [2:0] S_WAIT_ENC    = 3'd2;
    localparam logic [2:0] S_RESP_ENC    = 3'd3;
    localparam logic [2:0] S_RECOVER_ENC = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = S_IDLE_ENC,
        S_LAUNCH  = S_LAUNCH_ENC,
        S_WAIT    = S_WAIT_ENC,
        S_RESP    = S_RESP_ENC,
        S_RECOVER = S_RECOVER_ENC
    } state_t;

endpackage

// File: rtl/alu_arbiter_rr_picker.sv
// Round-robin picker: first valid index at or after ptr, wrapping at N.
// Purely combinational so any shared-resource arbiter can reuse it.
module rr_picker #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx,
    output logic [N-1:0]     onehot
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Scan offsets from farthest to nearest so the closest valid index to ptr wins.
    always_comb begin
        found    = 1'b0;
        idx      = '0;
        onehot   = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IDX_W'(cand);
            if (valid[cand_idx]) begin
                found = 1'b1;
                idx   = cand_idx;
            end
        end
        if (found) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one sequential 8-bit ALU among N_REQ requesters.
// Handshakes: a transfer happens on a clock edge where valid and ready are
// both high; req_ready is only offered in IDLE, and rsp_* are held stable
// while rsp_valid is high until rsp_ready is seen.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [DATA_W*N_REQ-1:0] req_x,
    input  logic [DATA_W*N_REQ-1:0] req_y,
    input  logic [OP_W*N_REQ-1:0]   req_op,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [RES_W-1:0]        rsp_data,
    output logic                    rsp_err,
    output logic [DATA_W-1:0]       alu_x,
    output logic [DATA_W-1:0]       alu_y,
    output logic [OP_W-1:0]         alu_op,
    output logic                    alu_begin,
    output logic                    alu_resetn,
    input  logic [RES_W-1:0]        alu_out,
    input  logic                    alu_end,
    output state_t                  dbg_state
);

    state_t            state;
    logic [ID_W-1:0]   ptr;
    logic [WDOG_W-1:0] wdog;
    logic              end_q;
    logic              end_rise;
    logic              pick_found;
    logic [ID_W-1:0]   pick_idx;
    logic [N_REQ-1:0]  pick_onehot;
    logic              accept;

    rr_picker #(
        .N     (N_REQ),
        .IDX_W (ID_W)
    ) u_picker (
        .valid  (req_valid),
        .ptr    (ptr),
        .found  (pick_found),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    // Grant is offered only in IDLE and never while reset is asserted.
    assign accept    = (state == S_IDLE) && pick_found && !reset;
    assign req_ready = accept ? pick_onehot : '0;
    assign dbg_state = state;

    // Only a fresh low-to-high END counts; a level left over from the last op is ignored.
    assign end_rise = alu_end & ~end_q;

    // Control FSM with registered datapath and ALU-side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            ptr        <= '0;
            wdog       <= '0;
            end_q      <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            alu_x      <= '0;
            alu_y      <= '0;
            alu_op     <= '0;
            alu_begin  <= 1'b0;
            alu_resetn <= 1'b0;
        end else begin
            end_q      <= alu_end;
            alu_begin  <= 1'b0;
            alu_resetn <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        alu_x     <= req_x[pick_idx*DATA_W +: DATA_W];
                        alu_y     <= req_y[pick_idx*DATA_W +: DATA_W];
                        alu_op    <= req_op[pick_idx*OP_W +: OP_W];
                        rsp_id    <= pick_idx;
                        ptr       <= (pick_idx == ID_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
                        alu_begin <= 1'b1;
                        state     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    wdog  <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // Completion is checked first so it wins a tie with the watchdog.
                    if (end_rise) begin
                        rsp_data  <= alu_out;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else if (wdog == WDOG_W'(TIMEOUT - 1)) begin
                        rsp_data   <= '0;
                        rsp_err    <= 1'b1;
                        alu_resetn <= 1'b0;
                        state      <= S_RECOVER;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                S_RECOVER: begin
                    rsp_valid <= 1'b1;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one task per scenario, inline checks.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [31:0] req_x = '0;
    logic [31:0] req_y = '0;
    logic [11:0] req_op = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic [7:0]  alu_x;
    logic [7:0]  alu_y;
    logic [2:0]  alu_op;
    logic        alu_begin;
    logic        alu_resetn;
    logic [15:0] alu_out = '0;
    logic        alu_end = 1'b0;
    state_t      dbg_state;

    // Second instance with a short watchdog for the timeout scenario.
    logic [3:0]  t_req_valid = '0;
    logic [3:0]  t_req_ready;
    logic        t_rsp_valid;
    logic        t_rsp_ready = 1'b0;
    logic [1:0]  t_rsp_id;
    logic [15:0] t_rsp_data;
    logic        t_rsp_err;
    logic [7:0]  t_alu_x;
    logic [7:0]  t_alu_y;
    logic [2:0]  t_alu_op;
    logic        t_alu_begin;
    logic        t_alu_resetn;
    logic [15:0] t_alu_out = 16'hFFFF;
    logic        t_alu_end = 1'b0;
    state_t      t_dbg_state;

    int checks = 0;
    int errors = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got hang want finish");
        $fatal(1);
    end

    alu_arbiter #(.N_REQ(4), .ID_W(2), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op),
        .alu_begin(alu_begin), .alu_resetn(alu_resetn),
        .alu_out(alu_out), .alu_end(alu_end),
        .dbg_state(dbg_state)
    );

    alu_arbiter #(.N_REQ(4), .ID_W(2), .TIMEOUT(8)) dut_to (
        .clk(clk), .reset(reset),
        .req_valid(t_req_valid), .req_ready(t_req_ready),
        .req_x(req_x), .req_y(req_y), .req_op(req_op),
        .rsp_valid(t_rsp_valid), .rsp_ready(t_rsp_ready),
        .rsp_id(t_rsp_id), .rsp_data(t_rsp_data), .rsp_err(t_rsp_err),
        .alu_x(t_alu_x), .alu_y(t_alu_y), .alu_op(t_alu_op),
        .alu_begin(t_alu_begin), .alu_resetn(t_alu_resetn),
        .alu_out(t_alu_out), .alu_end(t_alu_end),
        .dbg_state(t_dbg_state)
    );

    // ---------------- driver tasks ----------------
    task automatic clk_step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = '0;
        repeat (3) clk_step();
        checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, S_IDLE); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
        checks++; if (alu_begin !== 1'b0) begin errors++; $display("FAIL reset_alu_begin: got %b want 0", alu_begin); end
        checks++; if (rsp_id !== 2'd0 || rsp_data !== 16'h0000) begin errors++; $display("FAIL reset_rsp_fields: got id %0d data %h want 0 0000", rsp_id, rsp_data); end
        checks++; if ({alu_x, alu_y, alu_op} !== 19'd0) begin errors++; $display("FAIL reset_alu_operands: got %h %h %h want 0", alu_x, alu_y, alu_op); end
        checks++; if (alu_resetn !== 1'b0) begin errors++; $display("FAIL reset_alu_resetn: got %b want 0", alu_resetn); end
        req_valid = 4'hF;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        req_valid = '0;
        reset = 1'b0;
        #1;
        checks++; if (alu_resetn !== 1'b0) begin errors++; $display("FAIL reset_resetn_extra: got %b want 0", alu_resetn); end
        clk_step();
        checks++; if (alu_resetn !== 1'b1) begin errors++; $display("FAIL reset_resetn_release: got %b want 1", alu_resetn); end
    endtask

    task automatic test_single();
        req_x[23:16] = 8'h0C;
        req_y[23:16] = 8'h05;
        req_op[8:6] = 3'b000;
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b want 0100", req_ready); end
        clk_step();
        req_valid = '0;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_ready_once: got %b want 0000", req_ready); end
        checks++; if (alu_begin !== 1'b1) begin errors++; $display("FAIL single_begin: got %b want 1", alu_begin); end
        checks++; if ({alu_x, alu_y, alu_op} !== {8'h0C, 8'h05, 3'b000}) begin errors++; $display("FAIL single_operands: got %h %h %h want 0c 05 0", alu_x, alu_y, alu_op); end
        for (int c = 1; c <= 10; c++) begin
            clk_step();
            if (c == 1) begin
                checks++; if (alu_begin !== 1'b0) begin errors++; $display("FAIL single_begin_width: got %b want 0", alu_begin); end
            end
            if (c == 10) begin
                checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_rsp: got %b want 0", rsp_valid); end
                alu_end = 1'b1;
                alu_out = 16'h0004;
            end
        end
        clk_step();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid: got %b want 1", rsp_valid); end
        checks++; if (rsp_id !== 2'd2 || rsp_data !== 16'h0004 || rsp_err !== 1'b0) begin errors++; $display("FAIL single_rsp: got id %0d data %h err %b want 2 0004 0", rsp_id, rsp_data, rsp_err); end
        rsp_ready = 1'b1;
        clk_step();
        rsp_ready = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || dbg_state !== S_IDLE) begin errors++; $display("FAIL single_done: got valid %b state %0d want 0 %0d", rsp_valid, dbg_state, S_IDLE); end
    endtask

    task automatic test_stale_end();
        bit ok;
        // alu_end is still high from the previous operation.
        req_x[15:8] = 8'h21;
        req_y[15:8] = 8'h03;
        req_op[5:3] = 3'b010;
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL stale_grant: got %b want 0010", req_ready); end
        clk_step();
        req_valid = '0;
        #1;
        checks++; if (alu_begin !== 1'b1) begin errors++; $display("FAIL stale_begin: got %b want 1", alu_begin); end
        ok = 1'b1;
        for (int c = 2; c <= 9; c++) begin
            clk_step();
            if (c == 4) alu_end = 1'b0;
            if (c == 9) begin
                alu_end = 1'b1;
                alu_out = 16'h1234;
            end
            #1;
            if (dbg_state !== S_WAIT || rsp_valid !== 1'b0) ok = 1'b0;
        end
        checks++; if (!ok) begin errors++; $display("FAIL stale_no_early: got early completion want WAIT until second rise"); end
        clk_step();
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 16'h1234) begin errors++; $display("FAIL stale_rsp: got valid %b id %0d data %h want 1 1 1234", rsp_valid, rsp_id, rsp_data); end
        rsp_ready = 1'b1;
        clk_step();
        rsp_ready = 1'b0;
        alu_end = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL stale_done: got %b want 0", rsp_valid); end
    endtask

    task automatic test_backpressure();
        bit ok;
        req_x[31:24] = 8'h77; req_y[31:24] = 8'h01; req_op[11:9] = 3'b001;
        req_x[7:0]   = 8'h11; req_y[7:0]   = 8'h22; req_op[2:0]  = 3'b011;
        req_valid = 4'b1001;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_grant: got %b want 1000", req_ready); end
        clk_step();
        req_valid = 4'b0001;
        clk_step();
        alu_end = 1'b1;
        alu_out = 16'hBEEF;
        clk_step();
        alu_end = 1'b0;
        ok = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) clk_step();
            #1;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== 16'hBEEF ||
                rsp_err !== 1'b0 || req_ready !== 4'b0000 || alu_x !== 8'h77) ok = 1'b0;
        end
        checks++; if (!ok) begin errors++; $display("FAIL bp_hold: got id %0d data %h ready %b want 3 beef 0000 held", rsp_id, rsp_data, req_ready); end
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_no_accept_in_resp: got %b want 0000", req_ready); end
        clk_step();
        rsp_ready = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_drop: got %b want 0", rsp_valid); end
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_next_grant: got %b want 0001", req_ready); end
        clk_step();
        req_valid = '0;
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        clk_step();
        clk_step();
        #1;
        checks++; if (dbg_state !== S_WAIT) begin errors++; $display("FAIL rmw_in_wait: got %0d want %0d", dbg_state, S_WAIT); end
        reset = 1'b1;
        clk_step();
        reset = 1'b0;
        #1;
        checks++; if (dbg_state !== S_IDLE || rsp_valid !== 1'b0) begin errors++; $display("FAIL rmw_idle: got state %0d valid %b want %0d 0", dbg_state, rsp_valid, S_IDLE); end
        checks++; if (rsp_data !== 16'h0000 || alu_x !== 8'h00) begin errors++; $display("FAIL rmw_cleared: got data %h x %h want 0000 00", rsp_data, alu_x); end
        checks++; if (alu_resetn !== 1'b0) begin errors++; $display("FAIL rmw_resetn_low: got %b want 0", alu_resetn); end
        clk_step();
        checks++; if (alu_resetn !== 1'b1) begin errors++; $display("FAIL rmw_resetn_high: got %b want 1", alu_resetn); end
        ok = 1'b1;
        for (int c = 0; c < 15; c++) begin
            alu_end = (c == 3);
            alu_out = 16'h5555;
            clk_step();
            if (rsp_valid !== 1'b0 || dbg_state !== S_IDLE) ok = 1'b0;
        end
        alu_end = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL rmw_no_response: got response or busy want idle"); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_q[$];
        logic [1:0] inflight_q[$];
        logic [1:0] g;
        logic [1:0] exp_id;
        int grants = 0;
        int resps = 0;
        int cnt = 0;
        int cyc = 0;
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 4; i++) req_x[i*8 +: 8] = 8'(16 + i);
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        while (resps < 5 && cyc < 200) begin
            if (grants >= 5) req_valid = '0;
            if (alu_begin) cnt = 3;
            else if (cnt > 0) cnt--;
            alu_end = (cnt == 1);
            alu_out = (inflight_q.size() > 0) ? (16'hA000 | 16'(inflight_q[0])) : 16'h0000;
            #1;
            if (req_ready !== 4'b0000) begin
                g = 2'd0;
                for (int i = 0; i < 4; i++) if (req_ready[i]) g = 2'(i);
                checks++;
                if ($countones(req_ready) != 1 || exp_q.size() == 0 || g !== exp_q[0]) begin
                    errors++;
                    $display("FAIL rr_grant: got %b want index %0d", req_ready, (exp_q.size() > 0) ? exp_q[0] : 2'd0);
                end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                inflight_q.push_back(g);
                grants++;
            end
            if (rsp_valid && rsp_ready) begin
                exp_id = (inflight_q.size() > 0) ? inflight_q.pop_front() : 2'd0;
                checks++;
                if (rsp_id !== exp_id || rsp_data !== (16'hA000 | 16'(exp_id)) || rsp_err !== 1'b0) begin
                    errors++;
                    $display("FAIL rr_rsp: got id %0d data %h want %0d %h", rsp_id, rsp_data, exp_id, 16'hA000 | 16'(exp_id));
                end
                resps++;
            end
            clk_step();
            cyc++;
        end
        rsp_ready = 1'b0;
        alu_end = 1'b0;
        checks++; if (grants != 5 || resps != 5) begin errors++; $display("FAIL rr_count: got grants %0d resps %0d want 5 5", grants, resps); end
    endtask

    task automatic test_timeout();
        int wait_cnt = 0;
        int low_cnt = 0;
        int cyc = 0;
        bit low_in_recover = 1'b1;
        t_req_valid = 4'b0010;
        #1;
        checks++; if (t_req_ready !== 4'b0010) begin errors++; $display("FAIL to_grant: got %b want 0010", t_req_ready); end
        clk_step();
        t_req_valid = '0;
        #1;
        checks++; if (t_alu_begin !== 1'b1) begin errors++; $display("FAIL to_begin: got %b want 1", t_alu_begin); end
        while (t_rsp_valid !== 1'b1 && cyc < 40) begin
            clk_step();
            cyc++;
            #1;
            if (t_dbg_state == S_WAIT) wait_cnt++;
            if (t_alu_resetn !== 1'b1) begin
                low_cnt++;
                if (t_dbg_state != S_RECOVER) low_in_recover = 1'b0;
            end
        end
        checks++; if (t_rsp_valid !== 1'b1) begin errors++; $display("FAIL to_rsp_seen: got %b want 1", t_rsp_valid); end
        checks++; if (wait_cnt != 8) begin errors++; $display("FAIL to_wait_cycles: got %0d want 8", wait_cnt); end
        checks++; if (low_cnt != 1 || !low_in_recover) begin errors++; $display("FAIL to_resetn_pulse: got %0d low cycles want 1 in RECOVER", low_cnt); end
        checks++; if (t_rsp_err !== 1'b1 || t_rsp_data !== 16'h0000 || t_rsp_id !== 2'd1) begin errors++; $display("FAIL to_rsp: got err %b data %h id %0d want 1 0000 1", t_rsp_err, t_rsp_data, t_rsp_id); end
        t_rsp_ready = 1'b1;
        clk_step();
        t_rsp_ready = 1'b0;
        #1;
        checks++; if (t_rsp_valid !== 1'b0 || t_dbg_state !== S_IDLE) begin errors++; $display("FAIL to_done: got valid %b state %0d want 0 %0d", t_rsp_valid, t_dbg_state, S_IDLE); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_stale_end();
        test_backpressure();
        test_reset_mid_wait();
        test_round_robin();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
